// File: rtl/obi_xbar_varlat_one_to_n_pkg.sv
// Shared bus payload types and helpers for the one-to-N OBI demultiplexer.
package obi_xbar_varlat_one_to_n_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;
  localparam int unsigned RuleIdxWidth = 32;

  // Address-map rule: the half-open window [start_addr, end_addr) selects slave idx.
  typedef struct packed {
    logic [RuleIdxWidth-1:0] idx;
    logic [AddrWidth-1:0]    start_addr;
    logic [AddrWidth-1:0]    end_addr;
  } addr_map_rule_t;

  // OBI request channel.
  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } obi_req_t;

  // OBI response channel.
  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
  } obi_resp_t;

  // Width of a slave index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_xbar_varlat_one_to_n_idx_fifo.sv
// xbar_idx_fifo: small FIFO of slave indices for outstanding OBI transactions.
// Push is ignored when full and pop is ignored when empty; rdata shows the head.
module xbar_idx_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push;
  logic                do_pop;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full    = (cnt_q == CntWidth'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

  // Index storage, cleared on reset so the head never reads as unknown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/obi_xbar_varlat_one_to_n.sv
// One-master-to-N-slave OBI demultiplexer with run-time address decoding and
// in-order, variable-latency response routing. Requests to a slave other than
// the one currently holding outstanding transactions stall until those drain.
// Optional simulation checks: define XBAR_VARLAT_ASSERT_EN.
module obi_xbar_varlat_one_to_n
  import obi_xbar_varlat_one_to_n_pkg::*;
#(
  parameter int unsigned XBAR_NSLAVE = 2,
  parameter int unsigned NUM_RULES   = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IdxWidth   = idx_width(XBAR_NSLAVE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  addr_map_rule_t      addr_map_i    [NUM_RULES],
  input  logic [IdxWidth-1:0] default_idx_i,
  input  obi_req_t            master_req_i,
  output obi_resp_t           master_resp_o,
  output obi_req_t            slave_req_o   [XBAR_NSLAVE],
  input  obi_resp_t           slave_resp_i  [XBAR_NSLAVE]
);

  logic                    rule_hit;
  logic [RuleIdxWidth-1:0] rule_idx;
  logic [IdxWidth-1:0]     target_idx;
  logic [IdxWidth-1:0]     head_idx;
  logic [IdxWidth-1:0]     last_idx_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    allowed;
  logic                    fwd_gnt;
  logic                    rsp_valid;
  logic [DataWidth-1:0]    rsp_data;
  logic                    push;
  logic                    pop;

  // Address decode: last matching rule wins; no match or out-of-range index falls back to default.
  always_comb begin
    rule_hit = 1'b0;
    rule_idx = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      if ((master_req_i.addr >= addr_map_i[r].start_addr) &&
          (master_req_i.addr <  addr_map_i[r].end_addr)) begin
        rule_hit = 1'b1;
        rule_idx = addr_map_i[r].idx;
      end
    end
    if (rule_hit && (rule_idx < RuleIdxWidth'(XBAR_NSLAVE))) begin
      target_idx = IdxWidth'(rule_idx);
    end else begin
      target_idx = default_idx_i;
    end
  end

  // Only one slave may hold outstanding transactions, which keeps responses in order.
  assign allowed = !fifo_full && (fifo_empty || (target_idx == last_idx_q));

  // Request steering and grant return.
  always_comb begin
    fwd_gnt = 1'b0;
    for (int unsigned s = 0; s < XBAR_NSLAVE; s++) begin
      slave_req_o[s] = '0;
      if (allowed && (target_idx == IdxWidth'(s))) begin
        slave_req_o[s] = master_req_i;
        fwd_gnt        = slave_resp_i[s].gnt;
      end
    end
  end

  // Response selection from the slave owning the oldest outstanding transaction.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    for (int unsigned s = 0; s < XBAR_NSLAVE; s++) begin
      if (!fifo_empty && (head_idx == IdxWidth'(s))) begin
        rsp_valid = slave_resp_i[s].rvalid;
        rsp_data  = slave_resp_i[s].rdata;
      end
    end
  end

  assign master_resp_o = '{gnt: fwd_gnt, rvalid: rsp_valid, rdata: rsp_data};

  assign push = master_req_i.req && fwd_gnt;
  assign pop  = rsp_valid;

  // Remember the slave of the most recent accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_idx_q <= '0;
    end else if (push) begin
      last_idx_q <= target_idx;
    end
  end

  xbar_idx_fifo #(
    .WIDTH (IdxWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_idx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (target_idx),
    .pop    (pop),
    .rdata  (head_idx),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef XBAR_VARLAT_ASSERT_EN
  // Protocol checks on slave responses and on the tracking FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned s = 0; s < XBAR_NSLAVE; s++) begin
        if (slave_resp_i[s].rvalid) begin
          assert (!fifo_empty)
            else $error("slave %0d rvalid with no outstanding transaction", s);
          assert (fifo_empty || (head_idx == IdxWidth'(s)))
            else $error("slave %0d rvalid while head is slave %0d", s, head_idx);
        end
      end
      if (master_req_i.req) begin
        assert (!$isunknown(target_idx))
          else $error("unknown target index on request");
      end
      assert (!(push && fifo_full))
        else $error("push into full index FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_obi_xbar_varlat_one_to_n.sv
// Randomized scoreboard bench for obi_xbar_varlat_one_to_n.
module tb_obi_xbar_varlat_one_to_n;
  import obi_xbar_varlat_one_to_n_pkg::*;

  localparam int NS    = 3;
  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  addr_map_rule_t addr_map_i [NR];
  logic [IW-1:0]  default_idx_i;
  obi_req_t       master_req_i;
  obi_resp_t      master_resp_o;
  obi_req_t       slave_req_o [NS];
  obi_resp_t      slave_resp_i [NS];

  obi_xbar_varlat_one_to_n #(
    .XBAR_NSLAVE (NS),
    .NUM_RULES   (NR),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .addr_map_i    (addr_map_i),
    .default_idx_i (default_idx_i),
    .master_req_i  (master_req_i),
    .master_resp_o (master_resp_o),
    .slave_req_o   (slave_req_o),
    .slave_resp_i  (slave_resp_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          tgt;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] pend [NS][$];
  logic [31:0] addr_pool [$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_hs = 0;
  int last_tgt = 0;
  int p_gnt = 100, p_rv = 50, p_req = 80;
  bit drain = 1'b0;
  bit hold = 1'b0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference decode: scan rules from highest index down, first hit wins.
  function automatic int decode(input logic [31:0] a);
    for (int r = NR - 1; r >= 0; r--) begin
      if (addr_map_i[r].start_addr <= a && a < addr_map_i[r].end_addr) begin
        if (addr_map_i[r].idx < 32'(NS)) return int'(addr_map_i[r].idx);
        return int'(default_idx_i);
      end
    end
    return int'(default_idx_i);
  endfunction

  // Data a slave returns for an accepted request.
  function automatic logic [31:0] rd_of(input logic [31:0] a, input int s);
    return a ^ (32'hA5C3_0000 + 32'(s) * 32'h0101_0101);
  endfunction

  function automatic int pend_total();
    int n = 0;
    for (int s = 0; s < NS; s++) n += pend[s].size();
    return n;
  endfunction

  function automatic logic [31:0] next_addr();
    int r;
    logic [31:0] st, en, span;
    if (addr_pool.size() > 0) return addr_pool[$urandom_range(addr_pool.size() - 1)];
    r  = int'($urandom_range(NR - 1));
    st = addr_map_i[r].start_addr;
    en = addr_map_i[r].end_addr;
    span = en - st + 32'd1;
    case ($urandom_range(5))
      0: return st;
      1: return st - 32'd1;
      2: return en;
      3: return en - 32'd1;
      4: return st + ((span == 32'd0) ? 32'd0 : ($urandom % span));
      default: return $urandom;
    endcase
  endfunction

  // Request-side model: expected grant and routing, records accepted transactions.
  always @(negedge clk_i) begin : req_mon
    int t;
    bit allow;
    obi_req_t er;
    if (!rst_ni) sb.delete();
    t = decode(master_req_i.addr);
    allow = (sb.size() < DEPTH) && (sb.size() == 0 || t == last_tgt);
    chk("gnt", 128'(master_resp_o.gnt), 128'(allow && slave_resp_i[t].gnt));
    for (int s = 0; s < NS; s++) begin
      er = (allow && s == t) ? master_req_i : '0;
      chk($sformatf("slave_req[%0d]", s), 128'(slave_req_o[s]), 128'(er));
    end
    if (rst_ni && master_req_i.req && allow && slave_resp_i[t].gnt) begin
      sb.push_back('{tgt: t, data: rd_of(master_req_i.addr, t), cyc: cyc});
      last_tgt = t;
      n_hs++;
    end
    hold = master_req_i.req && !master_resp_o.gnt;
  end

  // Response monitor: pops the oldest expected response when its slave answers.
  always @(negedge clk_i) begin : rsp_mon
    bit ev;
    exp_t e;
    #1;
    ev = (sb.size() > 0) && (sb[0].cyc < cyc) && slave_resp_i[sb[0].tgt].rvalid;
    chk("rvalid", 128'(master_resp_o.rvalid), 128'(ev));
    if (ev) begin
      e = sb.pop_front();
      chk("rdata", 128'(master_resp_o.rdata), 128'(e.data));
    end else if (sb.size() == 0) begin
      chk("rdata_idle", 128'(master_resp_o.rdata), 128'(0));
    end
  end

  // Slave models: queue response data for every request they grant.
  always @(negedge clk_i) begin : slv_bfm
    #2;
    for (int s = 0; s < NS; s++) begin
      if (slave_req_o[s].req && slave_resp_i[s].gnt)
        pend[s].push_back(rd_of(slave_req_o[s].addr, s));
    end
  end

  task automatic tick(input bit idle);
    @(posedge clk_i);
    #1;
    for (int s = 0; s < NS; s++) begin
      slave_resp_i[s].gnt = ($urandom_range(99) < p_gnt);
      if (pend[s].size() > 0 && (drain || $urandom_range(99) < p_rv)) begin
        slave_resp_i[s].rvalid = 1'b1;
        slave_resp_i[s].rdata  = pend[s].pop_front();
      end else begin
        slave_resp_i[s].rvalid = 1'b0;
        slave_resp_i[s].rdata  = $urandom;
      end
    end
    if (idle) begin
      master_req_i.req = 1'b0;
    end else if (!hold) begin
      master_req_i.req   = ($urandom_range(99) < p_req);
      master_req_i.we    = 1'($urandom_range(1));
      master_req_i.be    = 4'($urandom);
      master_req_i.addr  = next_addr();
      master_req_i.wdata = $urandom;
    end
  endtask

  task automatic drain_all();
    int k = 0;
    drain = 1'b1;
    while ((sb.size() > 0 || pend_total() > 0) && k < 100) begin
      tick(1'b1);
      k++;
    end
    tick(1'b1);
    tick(1'b1);
    drain = 1'b0;
    chk("drain_done", 128'(sb.size() + pend_total()), 128'(0));
  endtask

  task automatic do_reset();
    tick(1'b1);
    #2 rst_ni = 1'b0;
    drain = 1'b1;
    repeat (3) tick(1'b1);
    #2 rst_ni = 1'b1;
    drain_all();
  endtask

  task automatic set_rule(input int r, input logic [31:0] idx, input logic [31:0] st, input logic [31:0] en);
    addr_map_i[r].idx        = idx;
    addr_map_i[r].start_addr = st;
    addr_map_i[r].end_addr   = en;
  endtask

  task automatic rand_map();
    logic [31:0] st;
    for (int r = 0; r < NR; r++) begin
      st = $urandom & 32'hFFFF_F000;
      set_rule(r, 32'($urandom_range(4)), st, st + 32'($urandom_range(32'h3000)));
    end
    if ($urandom_range(3) == 0) set_rule(1, addr_map_i[1].idx, addr_map_i[0].start_addr, addr_map_i[0].end_addr);
    default_idx_i = IW'($urandom_range(NS - 1));
  endtask

  initial begin
    int hs0;
    set_rule(0, 32'd1, 32'hF000_0000, 32'hF100_0000);
    set_rule(1, 32'd0, 32'h0, 32'h0);
    default_idx_i = '0;
    master_req_i  = '0;
    for (int s = 0; s < NS; s++) slave_resp_i[s] = '0;

    // Reset state, then release.
    repeat (3) tick(1'b1);
    #2 rst_ni = 1'b1;

    // Single-rule map with boundary addresses.
    addr_map_pool_a: begin
      addr_pool = '{32'hF000_0010, 32'h0000_0100, 32'hF100_0000,
                    32'hF000_0000, 32'hF0FF_FFFF, 32'hEFFF_FFFF};
      p_gnt = 70; p_rv = 40; p_req = 80;
      repeat (200) tick(1'b0);
      drain_all();
    end

    // Back-to-back to slave 0 with no responses: only DEPTH are granted.
    addr_pool = '{32'h0000_0100};
    p_gnt = 100; p_rv = 0; p_req = 100;
    hs0 = n_hs;
    repeat (8) tick(1'b0);
    @(negedge clk_i);
    #3;
    chk("b2b_grants", 128'(n_hs - hs0), 128'(DEPTH));
    p_rv = 100;
    repeat (10) tick(1'b0);
    @(negedge clk_i);
    #3;
    chk("b2b_resumed", 128'(n_hs - hs0 > DEPTH), 128'(1));
    drain_all();

    // Overlapping rules: higher rule index wins; outside falls to default.
    set_rule(0, 32'd0, 32'h0000_1000, 32'h0000_2000);
    set_rule(1, 32'd1, 32'h0000_1000, 32'h0000_2000);
    default_idx_i = 2'd2;
    addr_pool = '{32'h0000_1000, 32'h0000_1800, 32'h0000_1FFF, 32'h0000_2000, 32'h0000_0FFF};
    p_gnt = 60; p_rv = 50; p_req = 90;
    repeat (150) tick(1'b0);
    drain_all();

    // Reset with two reads outstanding; late slave responses must be dropped.
    set_rule(0, 32'd1, 32'hF000_0000, 32'hF100_0000);
    set_rule(1, 32'd0, 32'h0, 32'h0);
    default_idx_i = '0;
    addr_pool = '{32'h0000_0100};
    p_gnt = 100; p_rv = 0; p_req = 100;
    repeat (2) tick(1'b0);
    do_reset();

    // Randomized maps, including out-of-range rule indices.
    addr_pool.delete();
    for (int round = 0; round < 8; round++) begin
      rand_map();
      p_gnt = int'($urandom_range(30, 100));
      p_rv  = int'($urandom_range(20, 100));
      p_req = int'($urandom_range(50, 100));
      repeat (250) tick(1'b0);
      if (round == 4) do_reset();
    end
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
